// File: rtl/beehive_dbi_encoder.sv
// Data-bus-inversion encoder: one registered output stage that sends each word true or
// inverted, whichever toggles fewer wires. Optional inverted-word counter under BEEHIVE_DBI_STATS_EN.
module beehive_dbi_encoder #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             src_val,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_rdy,
  output logic             dst_val,
  output logic [WIDTH-1:0] dst_data,
  output logic             dst_inv,
  input  logic             dst_rdy,
  output logic [CNT_W-1:0] inv_cnt
);

  localparam int TW = $clog2(WIDTH) + 1;
  localparam logic [TW-1:0] HALF = TW'(WIDTH / 2);

  logic             dst_val_q, dst_val_d;
  logic             dst_inv_q, dst_inv_d;
  logic [WIDTH-1:0] last_wire_q, last_wire_d;
  logic [WIDTH-1:0] diff;
  logic [TW-1:0]    tcount;
  logic             accept;
  logic             send;
  logic             invert;

  assign src_rdy = ~dst_val_q | dst_rdy;
  assign accept  = src_val & src_rdy;
  assign send    = dst_val_q & dst_rdy;

  // The output data register doubles as last_wire: both load the same encoded value.
  assign diff = src_data ^ last_wire_q;

  always_comb begin
    tcount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tcount = tcount + {{(TW-1){1'b0}}, diff[i]};
    end
  end

  // A tie at exactly half the bus stays in true polarity.
  assign invert = tcount > HALF;

  always_comb begin
    dst_val_d   = dst_val_q;
    dst_inv_d   = dst_inv_q;
    last_wire_d = last_wire_q;
    if (accept) begin
      dst_val_d   = 1'b1;
      dst_inv_d   = invert;
      last_wire_d = invert ? ~src_data : src_data;
    end else if (send) begin
      dst_val_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_val_q   <= 1'b0;
      dst_inv_q   <= 1'b0;
      last_wire_q <= '0;
    end else begin
      dst_val_q   <= dst_val_d;
      dst_inv_q   <= dst_inv_d;
      last_wire_q <= last_wire_d;
    end
  end

  assign dst_val  = dst_val_q;
  assign dst_inv  = dst_inv_q;
  assign dst_data = last_wire_q;

`ifdef BEEHIVE_DBI_STATS_EN
  logic [CNT_W-1:0] inv_cnt_q, inv_cnt_d;

  always_comb begin
    inv_cnt_d = inv_cnt_q;
    if (send && dst_inv_q) begin
      inv_cnt_d = inv_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_cnt_q <= '0;
    end else begin
      inv_cnt_q <= inv_cnt_d;
    end
  end

  assign inv_cnt = inv_cnt_q;
`else
  assign inv_cnt = '0;
`endif

endmodule

// File: tb/tb_beehive_dbi_encoder.sv
// Directed self-checking bench for beehive_dbi_encoder at WIDTH=8.
// Expected inv_cnt follows BEEHIVE_DBI_STATS_EN: real counts when defined, zero otherwise.
module tb_beehive_dbi_encoder;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
`ifdef BEEHIVE_DBI_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             src_val;
  logic [WIDTH-1:0] src_data;
  logic             src_rdy;
  logic             dst_val;
  logic [WIDTH-1:0] dst_data;
  logic             dst_inv;
  logic             dst_rdy;
  logic [CNT_W-1:0] inv_cnt;

  int checks = 0;
  int errors = 0;

  beehive_dbi_encoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_val(src_val), .src_data(src_data), .src_rdy(src_rdy),
    .dst_val(dst_val), .dst_data(dst_data), .dst_inv(dst_inv),
    .dst_rdy(dst_rdy), .inv_cnt(inv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
    src_val  = v;
    src_data = d;
    dst_rdy  = r;
  endtask

  task automatic checkWord(input string tag, input logic v, input logic [WIDTH-1:0] d, input logic inv);
    checkOutput({tag, "_val"}, 32'(dst_val), 32'(v));
    checkOutput({tag, "_data"}, 32'(dst_data), 32'(d));
    checkOutput({tag, "_inv"}, 32'(dst_inv), 32'(inv));
  endtask

  function automatic logic [31:0] expCnt(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    #3;
    checkWord("reset", 1'b0, 8'h00, 1'b0);
    checkOutput("reset_cnt", 32'(inv_cnt), 32'd0);
    checkOutput("reset_src_rdy", 32'(src_rdy), 32'd1);
    tick();
    rst_n = 1'b1;

    // 0xFF against all-zeros toggles 8 wires -> inverted; 0x0F against 0x00 is a tie.
    applyStimulus(1'b1, 8'hFF, 1'b1);
    checkOutput("idle_src_rdy", 32'(src_rdy), 32'd1);
    tick();
    checkWord("ff", 1'b1, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h0F, 1'b1);
    tick();
    checkWord("tie_0f", 1'b1, 8'h0F, 1'b0);
    checkOutput("cnt_after_ff", 32'(inv_cnt), expCnt(1));

    applyStimulus(1'b1, 8'h00, 1'b1);
    tick();
    checkWord("w00", 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hFE, 1'b1);
    tick();
    checkWord("wfe", 1'b1, 8'h01, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("drain_val", 32'(dst_val), 32'd0);
    checkOutput("cnt_after_fe", 32'(inv_cnt), expCnt(2));

    // Stall: 0xAA against last wire 0x01 toggles 5 -> sent as 0x55 inverted.
    applyStimulus(1'b1, 8'hAA, 1'b0);
    tick();
    checkWord("stall_load", 1'b1, 8'h55, 1'b1);
    applyStimulus(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_src_rdy", 32'(src_rdy), 32'd0);
      tick();
      checkWord("stall_hold", 1'b1, 8'h55, 1'b1);
    end
    dst_rdy = 1'b1;
    #1;
    checkOutput("release_src_rdy", 32'(src_rdy), 32'd1);
    tick();
    checkWord("after_stall_33", 1'b1, 8'h33, 1'b0);
    checkOutput("cnt_after_stall", 32'(inv_cnt), expCnt(3));
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("drain2_val", 32'(dst_val), 32'd0);

    // Alternating stream from last wire 0x33: wire stays 0x55, polarity alternates 0,1,0,1...
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, (i % 2 == 0) ? 8'h55 : 8'hAA, 1'b1);
      checkOutput("stream_src_rdy", 32'(src_rdy), 32'd1);
      tick();
      checkWord("stream", 1'b1, 8'h55, (i % 2 == 1));
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("stream_drain_val", 32'(dst_val), 32'd0);
    checkOutput("cnt_after_stream", 32'(inv_cnt), expCnt(11));

    // Async reset mid-stall with an inverted word pending.
    applyStimulus(1'b1, 8'hAA, 1'b0);
    tick();
    checkWord("pre_rst", 1'b1, 8'h55, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkWord("async_rst", 1'b0, 8'h00, 1'b0);
    checkOutput("async_rst_cnt", 32'(inv_cnt), 32'd0);
    checkOutput("async_rst_src_rdy", 32'(src_rdy), 32'd1);
    tick();
    rst_n = 1'b1;

    // First decision after reset compares against zeros.
    applyStimulus(1'b1, 8'h0F, 1'b1);
    tick();
    checkWord("post_rst_0f", 1'b1, 8'h0F, 1'b0);
    applyStimulus(1'b1, 8'hF8, 1'b1);
    tick();
    checkWord("post_rst_f8", 1'b1, 8'h07, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("post_rst_cnt", 32'(inv_cnt), expCnt(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
